// File: rtl/mmio_port_bank.sv
// rtl/mmio_port_bank.sv - memory-mapped GPIO bank: OUT/IN per channel, optional edge capture and irq
// Edge capture (EDGE, EDGE_EN, history flop, irq) is built only when PORT_BANK_IRQ_EN is defined.
module mmio_port_bank #(
  parameter int          NPORTS    = 2,
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h800
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  input  logic                    we,
  input  logic                    re,
  output logic                    hit,
  output logic [31:0]             rdata,
  input  logic [NPORTS*WIDTH-1:0] port_in,
  output logic [NPORTS*WIDTH-1:0] port_out,
  output logic                    irq
);

  localparam int          NB   = NPORTS * WIDTH;
  localparam logic [32:0] SPAN = 33'(16 * NPORTS);

  logic [32:0]       off_ext;
  logic              in_range;
  logic [2:0]        chan;
  logic [1:0]        rsel;
  logic [NPORTS-1:0] sel;
  logic [NB-1:0]     out_q;
  logic [NB-1:0]     s1_q;
  logic [NB-1:0]     s2_q;

  // 33-bit offset keeps the range compare correct for bases near the top of the map
  assign off_ext  = {1'b0, addr} - {1'b0, BASE_ADDR};
  assign in_range = (addr >= BASE_ADDR) && (off_ext < SPAN);
  assign hit      = in_range && (addr[1:0] == 2'b00);
  assign chan     = off_ext[6:4];
  assign rsel     = off_ext[3:2];

  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      sel[p] = hit && (chan == 3'(p));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      s1_q <= port_in;
      s2_q <= s1_q;
      for (int p = 0; p < NPORTS; p++) begin
        if (we && sel[p] && (rsel == 2'd0)) begin
          out_q[p*WIDTH +: WIDTH] <= wdata[WIDTH-1:0];
        end
      end
    end
  end

  assign port_out = out_q;

`ifdef PORT_BANK_IRQ_EN
  logic [NB-1:0] s3_q;
  logic [NB-1:0] edge_q;
  logic [NB-1:0] en_q;
  logic [NB-1:0] rise;
  logic [NB-1:0] clr;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    clr = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (we && sel[p] && (rsel == 2'd2)) begin
        clr[p*WIDTH +: WIDTH] = wdata[WIDTH-1:0];
      end
    end
  end

  // A new rising edge is OR-ed in after the W1C mask so it is never lost
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_q   <= '0;
      edge_q <= '0;
      en_q   <= '0;
    end else begin
      s3_q   <= s2_q;
      edge_q <= (edge_q & ~clr) | rise;
      for (int p = 0; p < NPORTS; p++) begin
        if (we && sel[p] && (rsel == 2'd3)) begin
          en_q[p*WIDTH +: WIDTH] <= wdata[WIDTH-1:0];
        end
      end
    end
  end

  assign irq = |(edge_q & en_q);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (sel[p]) begin
        case (rsel)
          2'd0:    rdata = 32'(out_q[p*WIDTH +: WIDTH]);
          2'd1:    rdata = 32'(s2_q[p*WIDTH +: WIDTH]);
`ifdef PORT_BANK_IRQ_EN
          2'd2:    rdata = 32'(edge_q[p*WIDTH +: WIDTH]);
          2'd3:    rdata = 32'(en_q[p*WIDTH +: WIDTH]);
`endif
          default: rdata = '0;
        endcase
      end
    end
  end

  // Loads have no side effects, so re and the high address/data bits are not consumed
  logic unused_bits;
  assign unused_bits = ^{re, wdata, off_ext};

endmodule

// File: tb/tb_mmio_port_bank.sv
// tb/tb_mmio_port_bank.sv - self-checking bench for mmio_port_bank (expects PORT_BANK_IRQ_EN behaviour when defined)
module tb_mmio_port_bank;

`ifdef PORT_BANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h800;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic        re;
  logic        hit;
  logic [31:0] rdata;
  logic [15:0] port_in;
  logic [15:0] port_out;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  mmio_port_bank #(.NPORTS(2), .WIDTH(8), .BASE_ADDR(32'h800)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .hit(hit), .rdata(rdata), .port_in(port_in), .port_out(port_out), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: register contents per channel plus the history of port_in
  // values sampled at each clock edge; IN sees the value from two edges ago.
  logic [7:0]  out_m [2];
  logic [7:0]  edge_m[2];
  logic [7:0]  en_m  [2];
  logic [15:0] samples[$];

  function automatic logic [15:0] hist(input int k);
    if (samples.size() >= k) return samples[samples.size() - k];
    return 16'h0000;
  endfunction

  function automatic logic m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int ch;
    int rg;
    logic [15:0] h;
    if (!m_hit(a)) return 32'h0;
    ch = int'((a - BASE) / 16);
    rg = int'(((a - BASE) % 16) / 4);
    h  = hist(2);
    case (rg)
      0:       return 32'(out_m[ch]);
      1:       return 32'(h[ch*8 +: 8]);
      2:       return IRQ_EN ? 32'(edge_m[ch]) : 32'h0;
      default: return IRQ_EN ? 32'(en_m[ch]) : 32'h0;
    endcase
  endfunction

  function automatic logic m_irq();
    return IRQ_EN && (((edge_m[0] & en_m[0]) != 0) || ((edge_m[1] & en_m[1]) != 0));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      out_m[c] = 8'h00; edge_m[c] = 8'h00; en_m[c] = 8'h00;
    end
    samples.delete();
  endtask

  task automatic model_update();
    logic [15:0] rise;
    logic [7:0]  clr[2];
    int ch;
    int rg;
    rise   = hist(2) & ~hist(3);
    clr[0] = 8'h00;
    clr[1] = 8'h00;
    if (we && m_hit(addr)) begin
      ch = int'((addr - BASE) / 16);
      rg = int'(((addr - BASE) % 16) / 4);
      if (rg == 0) out_m[ch] = wdata[7:0];
      if (rg == 2) clr[ch]   = wdata[7:0];
      if (rg == 3) en_m[ch]  = wdata[7:0];
    end
    for (int c = 0; c < 2; c++) edge_m[c] = (edge_m[c] & ~clr[c]) | rise[c*8 +: 8];
    samples.push_back(port_in);
    if (samples.size() > 3) void'(samples.pop_front());
  endtask

  task automatic tick();
    if (reset) model_reset();
    else model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [15:0] pin);
    we = w; addr = a; wdata = d; port_in = pin; re = ~w;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_hit"},   32'(hit),      32'(m_hit(addr)));
    chk({tag, "_rdata"}, rdata,         m_read(addr));
    chk({tag, "_pout"},  32'(port_out), 32'({out_m[1], out_m[0]}));
    chk({tag, "_irq"},   32'(irq),      32'(m_irq()));
  endtask

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_hit;
    logic [31:0] exp_rd;
    logic [15:0] exp_po;
  } vec_t;

  vec_t tv[15];

  initial begin
    logic [15:0] pin;
    logic [31:0] ra;

    tv[0]  = '{1'b0, 32'h800, 32'h0,   1'b1, 32'h00, 16'h0000};
    tv[1]  = '{1'b1, 32'h800, 32'hA5,  1'b1, 32'h00, 16'h0000};
    tv[2]  = '{1'b0, 32'h800, 32'h0,   1'b1, 32'hA5, 16'h00A5};
    tv[3]  = '{1'b1, 32'h810, 32'h15A, 1'b1, 32'h00, 16'h00A5};
    tv[4]  = '{1'b0, 32'h810, 32'h0,   1'b1, 32'h5A, 16'h5AA5};
    tv[5]  = '{1'b1, 32'h820, 32'hFF,  1'b0, 32'h00, 16'h5AA5};
    tv[6]  = '{1'b1, 32'h802, 32'hFF,  1'b0, 32'h00, 16'h5AA5};
    tv[7]  = '{1'b1, 32'h7FC, 32'hFF,  1'b0, 32'h00, 16'h5AA5};
    tv[8]  = '{1'b1, 32'h804, 32'hFF,  1'b1, 32'h00, 16'h5AA5};
    tv[9]  = '{1'b0, 32'h804, 32'h0,   1'b1, 32'h00, 16'h5AA5};
    tv[10] = '{1'b0, 32'h800, 32'h0,   1'b1, 32'hA5, 16'h5AA5};
    tv[11] = '{1'b0, 32'h81C, 32'h0,   1'b1, 32'h00, 16'h5AA5};
    tv[12] = '{1'b0, 32'h81F, 32'h0,   1'b0, 32'h00, 16'h5AA5};
    tv[13] = '{1'b1, 32'h80C, 32'h01,  1'b1, 32'h00, 16'h5AA5};
    tv[14] = '{1'b0, 32'h80C, 32'h0,   1'b1, 32'(IRQ_EN), 16'h5AA5};

    reset = 1'b1;
    drive(1'b0, 32'h800, 32'h0, 16'h0000);
    model_reset();
    #1;
    chk("rst_hit",   32'(hit),      32'h1);
    chk("rst_rdata", rdata,         32'h0);
    chk("rst_pout",  32'(port_out), 32'h0);
    chk("rst_irq",   32'(irq),      32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(tv[i].w, tv[i].a, tv[i].d, 16'h0000);
      #1;
      chk($sformatf("tv%0d_hit", i),   32'(hit),      32'(tv[i].exp_hit));
      chk($sformatf("tv%0d_rdata", i), rdata,         tv[i].exp_rd);
      chk($sformatf("tv%0d_pout", i),  32'(port_out), 32'(tv[i].exp_po));
      tick();
    end

    // IN latency through the synchronizer
    do_reset();
    drive(1'b0, 32'h814, 32'h0, 16'h3C00);
    #1;
    chk("in_lat0", rdata, 32'h00);
    tick();
    chk("in_lat1", rdata, 32'h00);
    tick();
    chk("in_lat2", rdata, 32'h3C);
    tick();
    chk("in_lat3", rdata, 32'h3C);

    // Edge capture, irq and W1C clear
    do_reset();
    drive(1'b1, 32'h80C, 32'h01, 16'h0000);
    tick();
    drive(1'b0, 32'h808, 32'h0, 16'h0001);
    tick();
    chk("edge_e1", rdata, 32'h0);
    chk("irq_e1",  32'(irq), 32'h0);
    tick();
    chk("edge_e2", rdata, 32'h0);
    chk("irq_e2",  32'(irq), 32'h0);
    tick();
    chk("edge_e3", rdata, 32'(IRQ_EN));
    chk("irq_e3",  32'(irq), 32'(IRQ_EN));
    check_all("edge_e3m");
    drive(1'b1, 32'h808, 32'h01, 16'h0001);
    tick();
    drive(1'b0, 32'h808, 32'h0, 16'h0001);
    #1;
    chk("w1c_edge", rdata, 32'h0);
    chk("w1c_irq",  32'(irq), 32'h0);

    // Clear and new rising edge in the same cycle: set wins
    drive(1'b0, 32'h808, 32'h0, 16'h0000);
    tick(); tick(); tick();
    drive(1'b0, 32'h808, 32'h0, 16'h0001);
    tick(); tick();
    drive(1'b1, 32'h808, 32'h01, 16'h0001);
    #1;
    check_all("sw_pre");
    tick();
    drive(1'b0, 32'h808, 32'h0, 16'h0001);
    #1;
    chk("set_wins",     rdata, 32'(IRQ_EN));
    chk("set_wins_irq", 32'(irq), 32'(IRQ_EN));

    // Asynchronous reset mid-cycle, then an input held high through release
    drive(1'b1, 32'h800, 32'hFF, 16'h0001);
    tick();
    drive(1'b0, 32'h800, 32'h0, 16'h0001);
    #1;
    chk("pre_rst_pout", 32'(port_out), 32'h00FF);
    chk("pre_rst_irq",  32'(irq),      32'(IRQ_EN));
    reset = 1'b1;
    #1;
    chk("async_rst_pout",  32'(port_out), 32'h0);
    chk("async_rst_irq",   32'(irq),      32'h0);
    chk("async_rst_rdata", rdata,         32'h0);
    tick();
    chk("held_rst_pout", 32'(port_out), 32'h0);
    reset = 1'b0;
    model_reset();
    drive(1'b0, 32'h808, 32'h0, 16'h0001);
    tick(); tick();
    chk("rel_edge_e2", rdata, 32'h0);
    tick();
    chk("rel_edge_e3", rdata, 32'(IRQ_EN));
    chk("rel_irq",     32'(irq), 32'h0);

    // Randomized traffic against the model
    do_reset();
    pin = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      ra = 32'h7F0 + 32'($urandom_range(0, 16) * 4);
      if ($urandom_range(0, 7) == 0) ra = ra + 32'($urandom_range(1, 3));
      pin = pin ^ 16'($urandom & $urandom & $urandom);
      drive(1'($urandom_range(0, 1)), ra, $urandom, pin);
      #1;
      check_all($sformatf("rnd%0d", i));
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        #1;
        chk($sformatf("rnd%0d_rst_pout", i), 32'(port_out), 32'h0);
        chk($sformatf("rnd%0d_rst_irq", i),  32'(irq),      32'h0);
        reset = 1'b0;
        model_reset();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
